// File: rtl/keccak_round_sequencer_if.sv
// Handshake bundle between the permutation requester/consumer and the
// Keccak round sequencer.
// Optional feature macro: KECCAK_SEQ_ABORT_EN adds the 'abort' request line.
interface keccak_round_sequencer_if #(
    parameter int STEPS = 12
);
    logic             start;
    logic             ack;
`ifdef KECCAK_SEQ_ABORT_EN
    logic             abort;
`endif
    logic             ready;
    logic             load;
    logic [STEPS-1:0] i;
    logic             round_en;
    logic             done;

    // Requester / consumer side
    modport master (
        output start,
        output ack,
`ifdef KECCAK_SEQ_ABORT_EN
        output abort,
`endif
        input  ready,
        input  load,
        input  i,
        input  round_en,
        input  done
    );

    // Sequencer side
    modport slave (
        input  start,
        input  ack,
`ifdef KECCAK_SEQ_ABORT_EN
        input  abort,
`endif
        output ready,
        output load,
        output i,
        output round_en,
        output done
    );
endinterface

// File: rtl/keccak_round_sequencer.sv
// Keccak round sequencer: accepts a permutation request, walks a one-hot
// step index through STEPS double-round positions (one per clock), then
// holds a done flag until the consumer acknowledges. A done cycle that
// sees ack together with a new start launches the next permutation
// directly, giving one permutation every STEPS+1 cycles back-to-back.
// Optional feature macro: KECCAK_SEQ_ABORT_EN adds an abort request that
// returns RUN/DONE to IDLE and blocks start/ack in the same cycle.
module keccak_round_sequencer #(
    parameter int STEPS = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    keccak_round_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [STEPS-1:0] FIRST_STEP = {{(STEPS-1){1'b0}}, 1'b1};
    localparam logic [STEPS-1:0] NO_STEP    = '0;

    state_t           state_reg;
    state_t           state_next;
    logic [STEPS-1:0] i_reg;
    logic [STEPS-1:0] i_next;
    logic             round_en_reg;
    logic             round_en_next;
    logic             done_reg;
    logic             done_next;

    logic             ready;
    logic             load;
    logic             abort_req;
    logic [STEPS-1:0] i_shift;
    logic             last_step;

`ifdef KECCAK_SEQ_ABORT_EN
    assign abort_req = bus.abort;
`else
    assign abort_req = 1'b0;
`endif

    // One-hot advance: each step bit takes its lower neighbour, bit 0 empties.
    assign i_shift[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < STEPS; gi++) begin : g_shift
            assign i_shift[gi] = i_reg[gi-1];
        end
    endgenerate

    // The final double-round is the one where the top step bit is set.
    assign last_step = i_reg[STEPS-1];

    // State and registered outputs; reset clears everything immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            i_reg        <= NO_STEP;
            round_en_reg <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            i_reg        <= i_next;
            round_en_reg <= round_en_next;
            done_reg     <= done_next;
        end
    end

    // Next state and next step index.
    always_comb begin
        state_next = state_reg;
        i_next     = i_reg;
        unique case (state_reg)
            ST_IDLE: begin
                if (load) begin
                    state_next = ST_RUN;
                    i_next     = FIRST_STEP;
                end
            end
            ST_RUN: begin
                if (abort_req) begin
                    state_next = ST_IDLE;
                    i_next     = NO_STEP;
                end else if (last_step) begin
                    state_next = ST_DONE;
                    i_next     = NO_STEP;
                end else begin
                    i_next     = i_shift;
                end
            end
            ST_DONE: begin
                i_next = NO_STEP;
                if (abort_req) begin
                    state_next = ST_IDLE;
                end else if (bus.ack) begin
                    if (load) begin
                        state_next = ST_RUN;
                        i_next     = FIRST_STEP;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                i_next     = NO_STEP;
            end
        endcase
    end

    // Handshake outputs and the values the output flags take next cycle.
    always_comb begin
        ready         = 1'b0;
        load          = 1'b0;
        round_en_next = 1'b0;
        done_next     = 1'b0;
        unique case (state_reg)
            ST_IDLE: ready = 1'b1;
            ST_DONE: ready = bus.ack;
            default: ready = 1'b0;
        endcase
        // An abort request blocks any new start in the same cycle.
        if (abort_req) begin
            ready = 1'b0;
        end
        load          = bus.start & ready;
        round_en_next = (state_next == ST_RUN);
        done_next     = (state_next == ST_DONE);
    end

    assign bus.ready    = ready;
    assign bus.load     = load;
    assign bus.i        = i_reg;
    assign bus.round_en = round_en_reg;
    assign bus.done     = done_reg;

endmodule

// File: tb/tb_keccak_round_sequencer.sv
// Self-checking bench for keccak_round_sequencer: a per-cycle vector table
// for a single permutation with the ack-wait and ignored starts, a
// back-to-back run checked through an expected-done queue, an asynchronous
// reset mid-run, and abort cases when KECCAK_SEQ_ABORT_EN is defined.
module tb_keccak_round_sequencer;

    localparam int STEPS = 12;

    logic clk;
    logic reset;

    keccak_round_sequencer_if #(.STEPS(STEPS)) bus ();

    keccak_round_sequencer #(.STEPS(STEPS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             start;
        logic             ack;
        logic             exp_ready;
        logic             exp_load;
        logic [STEPS-1:0] exp_i;
        logic             exp_ren;
        logic             exp_done;
    } vec_t;

    vec_t vecs[20];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   exp_done_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Apply inputs for the current cycle; comb outputs settle 1 ns later.
    task automatic drive(input logic s, input logic a, input logic ab);
        bus.start = s;
        bus.ack   = a;
`ifdef KECCAK_SEQ_ABORT_EN
        bus.abort = ab;
`else
        if (ab) $display("note: abort requested but feature not built");
`endif
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not terminate");
        $fatal(1, "watchdog");
    end

    initial begin
        // Table: one permutation, start during RUN at i=010, 5-cycle ack wait
        // with start held (ignored), then ack alone, then idle.
        for (int k = 0; k < 20; k++) begin
            vecs[k].start     = 1'b0;
            vecs[k].ack       = 1'b0;
            vecs[k].exp_ready = 1'b0;
            vecs[k].exp_load  = 1'b0;
            vecs[k].exp_i     = '0;
            vecs[k].exp_ren   = 1'b0;
            vecs[k].exp_done  = 1'b0;
        end
        vecs[0].start     = 1'b1;
        vecs[0].exp_ready = 1'b1;
        vecs[0].exp_load  = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            vecs[k].start   = (k == 5);
            vecs[k].exp_i   = STEPS'(1) << (k - 1);
            vecs[k].exp_ren = 1'b1;
        end
        for (int k = 13; k <= 17; k++) begin
            vecs[k].start    = 1'b1;
            vecs[k].exp_done = 1'b1;
        end
        vecs[18].ack       = 1'b1;
        vecs[18].exp_done  = 1'b1;
        vecs[18].exp_ready = 1'b1;
        vecs[19].exp_ready = 1'b1;

        // Reset state
        reset = 1'b1;
        bus.start = 1'b0;
        bus.ack   = 1'b0;
`ifdef KECCAK_SEQ_ABORT_EN
        bus.abort = 1'b0;
`endif
        #2;
        chk("reset_i", 32'(bus.i), 32'h0);
        chk("reset_round_en", 32'(bus.round_en), 32'h0);
        chk("reset_done", 32'(bus.done), 32'h0);
        #10 reset = 1'b0;
        tick();
        drive(1'b1, 1'b0, 1'b0);
        chk("post_reset_load", 32'(bus.load), 32'h1);
        drive(1'b0, 1'b0, 1'b0);
        chk("post_reset_ready", 32'(bus.ready), 32'h1);
        chk("post_reset_load_low", 32'(bus.load), 32'h0);

        // Table-driven single permutation
        for (int k = 0; k < 20; k++) begin
            drive(vecs[k].start, vecs[k].ack, 1'b0);
            chk($sformatf("vec%0d_i", k), 32'(bus.i), 32'(vecs[k].exp_i));
            chk($sformatf("vec%0d_round_en", k), 32'(bus.round_en), 32'(vecs[k].exp_ren));
            chk($sformatf("vec%0d_done", k), 32'(bus.done), 32'(vecs[k].exp_done));
            chk($sformatf("vec%0d_ready", k), 32'(bus.ready), 32'(vecs[k].exp_ready));
            chk($sformatf("vec%0d_load", k), 32'(bus.load), 32'(vecs[k].exp_load));
            $display("vec %0d: start=%0b ack=%0b i=%03h round_en=%0b done=%0b ready=%0b load=%0b",
                     k, vecs[k].start, vecs[k].ack, bus.i, bus.round_en, bus.done, bus.ready, bus.load);
            tick();
        end

        // Back-to-back with start and ack held high: loads every 13 cycles,
        // each load schedules a done 13 cycles later.
        begin
            int k;
            k = 0;
            for (k = 0; k <= 39; k++) begin
                drive(1'b1, 1'b1, 1'b0);
                chk("b2b_load", 32'(bus.load), 32'((k % 13) == 0));
                if ((k % 13) != 0)
                    chk("b2b_i", 32'(bus.i), 32'(STEPS'(1) << ((k % 13) - 1)));
                if (bus.load) exp_done_q.push_back(k + 13);
                if (bus.done) begin
                    if (exp_done_q.size() == 0) begin
                        chk("b2b_unexpected_done", 32'(k), 32'hFFFF_FFFF);
                    end else begin
                        chk("b2b_done_cycle", 32'(k), 32'(exp_done_q.pop_front()));
                    end
                end
                $display("b2b %0d: i=%03h done=%0b load=%0b", k, bus.i, bus.done, bus.load);
                tick();
            end
            // Drain the final permutation with a bounded wait.
            while (!bus.done && k < 60) begin
                drive(1'b0, 1'b0, 1'b0);
                tick();
                k++;
            end
            if (!bus.done) begin
                chk("b2b_final_done_timeout", 32'h0, 32'h1);
            end else if (exp_done_q.size() == 0) begin
                chk("b2b_final_unexpected", 32'(k), 32'hFFFF_FFFF);
            end else begin
                chk("b2b_final_done_cycle", 32'(k), 32'(exp_done_q.pop_front()));
            end
            chk("b2b_queue_empty", 32'(exp_done_q.size()), 32'h0);
            drive(1'b0, 1'b1, 1'b0);
            tick();
            drive(1'b0, 1'b0, 1'b0);
            chk("b2b_back_idle_ready", 32'(bus.ready), 32'h1);
            chk("b2b_back_idle_done", 32'(bus.done), 32'h0);
        end

        // Asynchronous reset at i=040
        drive(1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0);
        repeat (6) tick();
        chk("rst_run_i_before", 32'(bus.i), 32'h040);
        #1 reset = 1'b1;
        #1;
        chk("rst_async_i", 32'(bus.i), 32'h0);
        chk("rst_async_round_en", 32'(bus.round_en), 32'h0);
        chk("rst_async_done", 32'(bus.done), 32'h0);
        $display("async reset: i=%03h round_en=%0b done=%0b", bus.i, bus.round_en, bus.done);
        #2 reset = 1'b0;
        tick();
        drive(1'b1, 1'b0, 1'b0);
        chk("rst_restart_load", 32'(bus.load), 32'h1);
        tick();
        drive(1'b0, 1'b0, 1'b0);
        chk("rst_restart_i", 32'(bus.i), 32'h001);
        chk("rst_restart_round_en", 32'(bus.round_en), 32'h1);
        repeat (12) tick();
        chk("rst_restart_done", 32'(bus.done), 32'h1);
        drive(1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0);

`ifdef KECCAK_SEQ_ABORT_EN
        // Abort in IDLE: no effect except ready low that cycle.
        drive(1'b1, 1'b0, 1'b1);
        chk("abort_idle_ready", 32'(bus.ready), 32'h0);
        chk("abort_idle_load", 32'(bus.load), 32'h0);
        tick();
        drive(1'b0, 1'b0, 1'b0);
        chk("abort_idle_round_en", 32'(bus.round_en), 32'h0);
        chk("abort_idle_ready_after", 32'(bus.ready), 32'h1);
        // Abort at i=020
        drive(1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0);
        repeat (5) tick();
        chk("abort_run_i_before", 32'(bus.i), 32'h020);
        drive(1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0);
        chk("abort_run_i", 32'(bus.i), 32'h0);
        chk("abort_run_round_en", 32'(bus.round_en), 32'h0);
        chk("abort_run_ready", 32'(bus.ready), 32'h1);
        begin
            int seen_done;
            seen_done = 0;
            for (int n = 0; n < 14; n++) begin
                if (bus.done) seen_done++;
                tick();
            end
            chk("abort_run_no_done", 32'(seen_done), 32'h0);
        end
        // Abort with start+ack in DONE
        drive(1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0);
        repeat (12) tick();
        chk("abort_done_reached", 32'(bus.done), 32'h1);
        drive(1'b1, 1'b1, 1'b1);
        chk("abort_done_ready", 32'(bus.ready), 32'h0);
        chk("abort_done_load", 32'(bus.load), 32'h0);
        tick();
        drive(1'b0, 1'b0, 1'b0);
        chk("abort_done_done", 32'(bus.done), 32'h0);
        chk("abort_done_i", 32'(bus.i), 32'h0);
        chk("abort_done_idle_ready", 32'(bus.ready), 32'h1);
        $display("abort in DONE: done=%0b i=%03h ready=%0b", bus.done, bus.i, bus.ready);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
